// File: rtl/cim_result_writeback.sv
// Captures CIM results, packs them into 32-bit words, buffers them in a FIFO and
// writes them back over valid/ready with an auto-incrementing address. Optional ReLU: CIM_WB_RELU_EN.
module cim_result_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CNT_W-1:0] num_results,
    input  logic             InFp,
    input  logic             cim_done,
    input  logic [21:0]      final_int,
    input  logic [7:0]       final_fp0,
    input  logic [7:0]       final_fp1,
    input  logic [7:0]       final_fp2,
    input  logic [7:0]       final_fp3,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [AW-1:0]    wb_addr,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic             job_done,
    output logic             overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             ovf_q, ovf_d;
    logic             jd_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic [31:0]      mem_q [DEPTH];

    logic        empty, full, pop, push_req, push, drop;
    logic [31:0] word;

    function automatic logic [31:0] pack_word(input logic fp_sel,
                                              input logic signed [21:0] ival,
                                              input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        logic signed [31:0] iext;
        logic [7:0]         p0, p1, p2, p3;
        iext = ival;
        p0 = b0; p1 = b1; p2 = b2; p3 = b3;
`ifdef CIM_WB_RELU_EN
        if (ival < 0) iext = '0;
        if (p0[7]) p0 = 8'h00;
        if (p1[7]) p1 = 8'h00;
        if (p2[7]) p2 = 8'h00;
        if (p3[7]) p3 = 8'h00;
`endif
        return fp_sel ? {p3, p2, p1, p0} : iext;
    endfunction

    assign word     = pack_word(InFp, final_int, final_fp0, final_fp1, final_fp2, final_fp3);
    assign empty    = (occ_q == '0);
    assign full     = (occ_q == OW'(DEPTH));
    assign pop      = !empty && wb_ready;
    assign push_req = cim_done && (state_q == RUN);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = pop ? addr_q + AW'(4) : addr_q;
        ovf_d   = ovf_q | drop;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    cnt_d   = num_results;
                    ovf_d   = 1'b0;
                    state_d = (num_results != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Dropped results still count towards the job length.
                if (cim_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN:   if (empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            jd_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            jd_q    <= (state_q == DONE);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is data only; validity comes from the reset occupancy counter.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= word;
    end

    assign wb_valid     = !empty;
    assign wb_data      = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign wb_addr      = addr_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign job_done     = jd_q;
    assign overflow_err = ovf_q;
endmodule

// File: tb/tb_cim_result_writeback.sv
// Randomized and directed bench for cim_result_writeback against a queue-based job model.
module tb_cim_result_writeback;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             RSTN, start, InFp, cim_done, wb_ready;
    logic [AW-1:0]    base_addr;
    logic [CNT_W-1:0] num_results;
    logic [21:0]      final_int;
    logic [7:0]       final_fp0, final_fp1, final_fp2, final_fp3;
    logic             wb_valid, busy, job_done, overflow_err;
    logic [AW-1:0]    wb_addr;
    logic [31:0]      wb_data;

    always #5 clk = ~clk;

    cim_result_writeback #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .RSTN(RSTN), .start(start), .base_addr(base_addr),
        .num_results(num_results), .InFp(InFp), .cim_done(cim_done),
        .final_int(final_int), .final_fp0(final_fp0), .final_fp1(final_fp1),
        .final_fp2(final_fp2), .final_fp3(final_fp3), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy),
        .job_done(job_done), .overflow_err(overflow_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Job model: phase of the job, a queue of pending words, the write address.
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    int               m_phase;
    logic [31:0]      m_q[$];
    logic [AW-1:0]    m_addr;
    int               m_left;
    logic             m_ovf, m_jd;
    logic [63:0]      xlog[$];
    int               jd_count;

    function automatic logic [31:0] model_word();
        longint v, f0, f1, f2, f3;
        v  = longint'(final_int);
        if (v >= 2097152) v -= 4194304;
        f0 = longint'(final_fp0); f1 = longint'(final_fp1);
        f2 = longint'(final_fp2); f3 = longint'(final_fp3);
`ifdef CIM_WB_RELU_EN
        if (v < 0) v = 0;
        if (f0 >= 128) f0 = 0;
        if (f1 >= 128) f1 = 0;
        if (f2 >= 128) f2 = 0;
        if (f3 >= 128) f3 = 0;
`endif
        if (InFp) return 32'(f3 * 16777216 + f2 * 65536 + f1 * 256 + f0);
        return 32'(v);
    endfunction

    task automatic model_edge();
        bit was_empty, was_full, popping;
        if (!RSTN) begin
            m_phase = M_IDLE; m_q.delete(); m_addr = '0; m_ovf = 0; m_jd = 0; m_left = 0;
            return;
        end
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        popping   = !was_empty && wb_ready;
        m_jd      = (m_phase == M_DONE);
        if (popping) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 4;
        end
        if (m_phase == M_RUN && cim_done) begin
            if (!was_full || popping) m_q.push_back(model_word());
            else m_ovf = 1;
        end
        case (m_phase)
            M_IDLE: if (start) begin
                m_addr  = base_addr;
                m_left  = int'(num_results);
                m_ovf   = 0;
                m_phase = (m_left != 0) ? M_RUN : M_DONE;
            end
            M_RUN: if (cim_done) begin
                m_left--;
                if (m_left == 0) m_phase = M_DRAIN;
            end
            M_DRAIN: if (was_empty) m_phase = M_DONE;
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("wb_valid", wb_valid, m_q.size() != 0);
        chk("wb_data", wb_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
        chk("wb_addr", wb_addr, m_addr);
        chk("busy", busy, (m_phase == M_RUN) || (m_phase == M_DRAIN));
        chk("job_done", job_done, m_jd);
        chk("overflow_err", overflow_err, m_ovf);
    endtask

    task automatic tick();
        if (RSTN && wb_valid && wb_ready) xlog.push_back({wb_addr, wb_data});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (job_done) jd_count++;
        compare_all();
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n, input logic fp);
        start = 1; base_addr = b; num_results = CNT_W'(n); InFp = fp;
        tick();
        start = 0;
    endtask

    task automatic pulse(input logic [21:0] iv, input logic [31:0] fpw);
        cim_done = 1; final_int = iv;
        {final_fp3, final_fp2, final_fp1, final_fp0} = fpw;
        tick();
        cim_done = 0;
    endtask

    initial begin
        RSTN = 0; start = 0; InFp = 0; cim_done = 0; wb_ready = 0;
        base_addr = '0; num_results = '0; final_int = '0;
        final_fp0 = '0; final_fp1 = '0; final_fp2 = '0; final_fp3 = '0;
        m_phase = M_IDLE; m_addr = '0; m_ovf = 0; m_jd = 0; m_left = 0; jd_count = 0;
        tick(); tick();
        RSTN = 1;
        tick();

        // Basic integer job
        wb_ready = 1; xlog.delete(); jd_count = 0;
        do_start(32'h1000, 2, 0);
        pulse(22'h3FFFFF, 32'h0);
        pulse(22'd5, 32'h0);
        repeat (6) tick();
        chk("int_nwrites", xlog.size(), 2);
        if (xlog.size() == 2) begin
`ifdef CIM_WB_RELU_EN
            chk("int_w0", xlog[0], {32'h1000, 32'h00000000});
`else
            chk("int_w0", xlog[0], {32'h1000, 32'hFFFFFFFF});
`endif
            chk("int_w1", xlog[1], {32'h1004, 32'h00000005});
        end
        chk("int_jd_once", jd_count, 1);
        chk("int_busy_after", busy, 0);

        // FP packing
        do_start(32'h2000, 1, 1);
        pulse(22'h0, 32'h84332211);
`ifdef CIM_WB_RELU_EN
        chk("fp_pack", wb_data, 32'h00332211);
`else
        chk("fp_pack", wb_data, 32'h84332211);
`endif
        repeat (4) tick();

        // Backpressure with overflow
        wb_ready = 0;
        do_start(32'h3000, 6, 0);
        for (int i = 0; i < 6; i++) pulse(22'($urandom), 32'h0);
        repeat (3) tick();
        chk("bp_ovf", overflow_err, 1);
        chk("bp_addr_hold", wb_addr, 32'h3000);
        chk("bp_busy", busy, 1);
        xlog.delete(); jd_count = 0; wb_ready = 1;
        repeat (8) tick();
        chk("bp_nwrites", xlog.size(), 4);
        for (int i = 0; i < 4 && i < xlog.size(); i++)
            chk("bp_addr_seq", xlog[i][63:32], 32'h3000 + 32'(4 * i));
        chk("bp_jd", jd_count, 1);

        // Full FIFO with simultaneous pop
        wb_ready = 0; xlog.delete();
        do_start(32'h4000, 7, 1);
        for (int i = 0; i < 4; i++) pulse(22'h0, $urandom);
        wb_ready = 1;
        for (int i = 0; i < 3; i++) pulse(22'h0, $urandom);
        chk("fullpop_ovf", overflow_err, 0);
        repeat (8) tick();
        chk("fullpop_nwrites", xlog.size(), 7);

        // Zero-length job, then cim_done while idle
        xlog.delete(); jd_count = 0;
        do_start(32'h5000, 0, 0);
        chk("zero_jd_early", job_done, 0);
        tick();
        chk("zero_jd", job_done, 1);
        pulse(22'd9, 32'h0);
        repeat (3) tick();
        chk("idle_no_write", xlog.size(), 0);
        chk("zero_jd_count", jd_count, 1);

        // Reset while draining with two words queued
        wb_ready = 0;
        do_start(32'h6000, 2, 0);
        pulse(22'd1, 32'h0);
        pulse(22'd2, 32'h0);
        tick();
        jd_count = 0;
        RSTN = 0;
        tick();
        RSTN = 1;
        chk("rst_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        wb_ready = 1;
        repeat (5) tick();
        chk("rst_no_jd", jd_count, 0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            RSTN        = ($urandom_range(0, 299) != 0);
            start       = ($urandom_range(0, 7) == 0);
            base_addr   = $urandom;
            num_results = CNT_W'($urandom_range(0, 10));
            InFp        = 1'($urandom);
            cim_done    = ($urandom_range(0, 2) != 0);
            final_int   = 22'($urandom);
            {final_fp3, final_fp2, final_fp1, final_fp0} = $urandom;
            wb_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        RSTN = 1; start = 0; cim_done = 0; wb_ready = 1;
        repeat (40) tick();
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cim_result_writeback.md
Name: cim_result_writeback

Overview:
Downstream of the CIM compute stage. Each time the compute stage pulses its done strobe, this block captures the integer result or the four FP8 results. It packs them into one 32-bit word, queues the word in a small FIFO, and drains it to the memory/bus side over a valid/ready handshake with an auto-incrementing address. A job-level FSM counts the expected results and signals job completion once every word has been written back.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 32, width of the write-back address.
CNT_W, 8, width of the result-count field and the internal counters.

Ports:
clk  input  1  clock
RSTN  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a job (used only in IDLE)
base_addr  input  AW  first write address; sampled on start
num_results  input  CNT_W  number of cim_done pulses expected in the job; sampled on start
InFp  input  1  result format: 0 = integer, 1 = FP8
cim_done  input  1  result-valid strobe from the compute stage
final_int  input  22  signed integer result; valid while cim_done=1
final_fp0..final_fp3  input  8 each  FP8 results {sign, exp[4:0], mant[1:0]}; valid while cim_done=1
wb_valid  output  1  write request
wb_ready  input  1  write accepted
wb_addr  output  AW  write address
wb_data  output  32  write data
busy  output  1  high in RUN and DRAIN
job_done  output  1  one-cycle completion pulse
overflow_err  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (RSTN=0 at a clk edge):
  - State = IDLE; FIFO is emptied.
  - wb_valid=0, wb_addr=0, wb_data=0, busy=0, job_done=0, overflow_err=0.
  - A reset in the middle of a job abandons it; no partial job_done is produced.
- Packing, decided on the cim_done cycle using InFp:
  - InFp=0: word = final_int sign-extended from 22 to 32 bits.
  - InFp=1: word = {final_fp3, final_fp2, final_fp1, final_fp0}.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start loads the address register with base_addr and the remaining count with num_results, and clears overflow_err.
    - If num_results != 0, go to RUN. If num_results == 0, go straight to DONE.
    - cim_done is ignored in IDLE.
  - RUN:
    - Each cim_done decrements the remaining count, whether or not the word is pushed.
    - The decrement that reaches 0 moves the FSM to DRAIN on the same edge.
    - start is ignored.
  - DRAIN:
    - Stays until the FIFO is empty, then goes to DONE.
    - cim_done is ignored.
  - DONE:
    - job_done=1 for exactly one cycle, then return to IDLE.
- FIFO:
  - Push on cim_done in RUN.
  - If the FIFO is full and there is no pop in the same cycle, the word is dropped and overflow_err is set; it stays set until the next accepted start.
  - Full with a simultaneous pop: the push is accepted.
  - Empty: a push and a pop cannot happen in the same cycle. A word written at edge N is first visible at N+1.
  - Read and write pointers wrap modulo DEPTH. A separate occupancy counter, 0..DEPTH, resolves full versus empty.
- Write-back handshake:
  - wb_valid = FIFO not empty. wb_data = FIFO head. wb_addr = current address register.
  - A transfer occurs at an edge where wb_valid && wb_ready. The transfer pops the FIFO and adds 4 to the address, wrapping modulo 2^AW.
  - wb_data and wb_addr hold stable while wb_valid=1 and wb_ready=0.
- Latency:
  - cim_done at edge N with the FIFO empty gives wb_valid=1 in the cycle after edge N.
  - With wb_ready held at 1, sustained throughput is one word per cycle.
- busy = (state == RUN) || (state == DRAIN).

Optional Feature:
Macro: CIM_WB_RELU_EN.
- Defined: ReLU is applied at packing time.
  - InFp=0: a negative final_int produces word 0x00000000.
  - InFp=1: each FP8 byte whose bit 7 is 1 is replaced by 8'h00, independently per byte.
- Not defined: results pass through unmodified.

Test Plan:
- Basic INT job:
  - Stimulus: start with base_addr=0x1000, num_results=2, InFp=0; cim_done with final_int=22'h3FFFFF (-1), then with final_int=5; wb_ready=1.
  - Required: writes (0x1000, 0xFFFFFFFF) then (0x1004, 0x00000005); job_done pulses once; busy=0 afterwards.
- FP packing:
  - Stimulus: InFp=1; fp0=0x11, fp1=0x22, fp2=0x33, fp3=0x84; num_results=1.
  - Required: wb_data=0x84332211. With CIM_WB_RELU_EN defined: wb_data=0x00332211.
- Backpressure and overflow:
  - Stimulus: DEPTH=4, wb_ready=0; six cim_done pulses with num_results=6.
  - Required: 4 words held with wb_data/wb_addr stable; overflow_err=1.
  - Then wb_ready=1: required exactly 4 writes at base+0..base+12, then job_done.
- Full FIFO with simultaneous pop:
  - Stimulus: FIFO full; cim_done in the same cycle as wb_valid&&wb_ready.
  - Required: no drop; overflow_err stays 0; occupancy stays at 4.
- Zero-length job and ignored inputs:
  - Stimulus: start with num_results=0.
  - Required: job_done two cycles after start, no wb_valid.
  - Stimulus: cim_done while in IDLE. Required: no write.
- Reset mid-job:
  - Stimulus: RSTN=0 for one edge while in DRAIN with 2 words queued.
  - Required: wb_valid=0 and busy=0 on the next cycle; no job_done.
